baudgen_prog: RTL and testbench

//  Runtime-programmable baud tick generator: successor to the fixed-rate TX divider.

---
 rtl/baudgen_prog.sv | 110 +++++++++++
 tb/tb_baudgen_prog.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/baudgen_prog.sv
// rtl/baudgen_prog.sv - runtime-programmable baud tick generator with TX/RX start modes
module baudgen_prog #(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 104
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             ena,
    input  logic             mode,
    input  logic [DIV_W-1:0] div_in,
    input  logic             div_load,
    output logic             tick,
    output logic             run,
    output logic [DIV_W-1:0] div_cur,
    output logic             div_err
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);
    localparam logic [DIV_W-1:0] TWO = DIV_W'(2);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] pend_val;
    logic             pend_vld;

    logic             load_ok;
    logic [DIV_W-1:0] d_start;
    logic [DIV_W-1:0] h_start;
    logic             wrap;

    // Load qualification and the divisor a start on this edge will use
    always_comb begin
        load_ok = div_load && (div_in >= TWO);
        d_start = load_ok ? div_in : div_cur;
        h_start = d_start >> 1;
        wrap    = (cnt == (div_cur - ONE));
    end

    // Tick FSM: counter runs 0..D-1, tick is raised on the edge where it wraps
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            cnt      <= '0;
            pend_val <= '0;
            pend_vld <= 1'b0;
            div_cur  <= DIV_W'(DEFAULT_DIV);
            tick     <= 1'b0;
            run      <= 1'b0;
            div_err  <= 1'b0;
        end else begin
            tick    <= 1'b0;
            div_err <= div_load && !load_ok;
            case (state)
                IDLE: begin
                    if (load_ok) begin
                        div_cur <= div_in;
                    end
                    if (ena) begin
                        state <= RUN;
                        run   <= 1'b1;
                        if (!mode) begin
                            // TX: tick immediately, next one D edges later
                            tick <= 1'b1;
                            cnt  <= '0;
                        end else begin
                            // RX: preset so the first wrap lands H edges from now
                            cnt <= d_start - h_start;
                        end
                    end
                end
                RUN: begin
                    if (!ena) begin
                        state    <= IDLE;
                        run      <= 1'b0;
                        cnt      <= '0;
                        pend_vld <= 1'b0;
                        if (load_ok) begin
                            div_cur <= div_in;
                        end else if (pend_vld) begin
                            div_cur <= pend_val;
                        end
                    end else if (wrap) begin
                        // Period boundary: the only point a new divisor may take effect
                        tick     <= 1'b1;
                        cnt      <= '0;
                        pend_vld <= 1'b0;
                        if (load_ok) begin
                            div_cur <= div_in;
                        end else if (pend_vld) begin
                            div_cur <= pend_val;
                        end
                    end else begin
                        cnt <= cnt + ONE;
                        if (load_ok) begin
                            pend_vld <= 1'b1;
                            pend_val <= div_in;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_baudgen_prog.sv
// tb/tb_baudgen_prog.sv - self-checking bench for baudgen_prog
module tb_baudgen_prog;

    localparam int DIV_W = 16;

    logic             clk = 1'b0;
    logic             rstn;
    logic             ena;
    logic             mode;
    logic [DIV_W-1:0] div_in;
    logic             div_load;
    logic             tick;
    logic             run;
    logic [DIV_W-1:0] div_cur;
    logic             div_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t0    = 0;

    int exp_q[$];
    int obs_q[$];

    typedef struct {
        logic [DIV_W-1:0] v_in;
        logic             v_err;
        logic [DIV_W-1:0] v_cur;
    } load_vec_t;

    load_vec_t vecs[6];

    baudgen_prog #(.DIV_W(DIV_W), .DEFAULT_DIV(104)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .ena      (ena),
        .mode     (mode),
        .div_in   (div_in),
        .div_load (div_load),
        .tick     (tick),
        .run      (run),
        .div_cur  (div_cur),
        .div_err  (div_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observed side of the scoreboard: absolute cycle of every tick
    always @(negedge clk) begin
        if (tick === 1'b1) obs_q.push_back(cyc);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc - t0);
        end
    endtask

    task automatic begin_scn();
        @(negedge clk);
        t0 = cyc;
    endtask

    task automatic goto(input int e);
        while (cyc - t0 < e) @(negedge clk);
    endtask

    task automatic expect_tick(input int rel);
        exp_q.push_back(t0 + rel);
    endtask

    task automatic settle(input string name);
        int o;
        while (exp_q.size() > 0) begin
            int e;
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
            chk({name, "_tick_cycle"}, o - t0, e - t0);
        end
        chk({name, "_extra_ticks"}, obs_q.size(), 0);
        obs_q.delete();
    endtask

    // Start a TX/RX run at edge 0 while loading divisor d on the same edge
    task automatic start_with(input int d, input logic m);
        begin_scn();
        div_in   = DIV_W'(d);
        div_load = 1'b1;
        ena      = 1'b1;
        mode     = m;
        goto(1);
        div_load = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; ena = 1'b0; mode = 1'b0; div_in = '0; div_load = 1'b0;
        vecs[0] = '{v_in: 16'd0,     v_err: 1'b1, v_cur: 16'd10};
        vecs[1] = '{v_in: 16'd1,     v_err: 1'b1, v_cur: 16'd10};
        vecs[2] = '{v_in: 16'd2,     v_err: 1'b0, v_cur: 16'd2};
        vecs[3] = '{v_in: 16'd65535, v_err: 1'b0, v_cur: 16'd65535};
        vecs[4] = '{v_in: 16'd1,     v_err: 1'b1, v_cur: 16'd65535};
        vecs[5] = '{v_in: 16'd104,   v_err: 1'b0, v_cur: 16'd104};

        repeat (3) @(negedge clk);
        chk("rst_tick", tick, 0);
        chk("rst_run", run, 0);
        chk("rst_err", div_err, 0);
        chk("rst_div", div_cur, 104);
        rstn = 1'b1;

        // Default divisor, TX start at edge 10
        begin_scn();
        goto(10);
        chk("s1_run_before", run, 0);
        ena = 1'b1; mode = 1'b0;
        expect_tick(11); expect_tick(115); expect_tick(219);
        goto(11);
        chk("s1_run_after", run, 1);
        goto(220);
        ena = 1'b0;
        goto(221);
        chk("s1_run_off", run, 0);
        settle("s1");

        // RX start, D=10 (H=5); mode change mid-run is ignored
        start_with(10, 1'b1);
        mode = 1'b0;
        chk("s2_div", div_cur, 10);
        expect_tick(6); expect_tick(16); expect_tick(26);
        goto(27);
        ena = 1'b0;
        goto(28);
        settle("s2a");

        // RX start, D=3 (H=1)
        start_with(3, 1'b1);
        expect_tick(2); expect_tick(5); expect_tick(8);
        goto(9);
        ena = 1'b0;
        goto(10);
        settle("s2b");

        // Divisor change while running takes effect at the next tick
        start_with(10, 1'b0);
        goto(4);
        div_in = 16'd20; div_load = 1'b1;
        goto(5);
        div_load = 1'b0;
        expect_tick(1); expect_tick(11); expect_tick(31); expect_tick(51); expect_tick(71);
        goto(10);
        chk("s3_div_old", div_cur, 10);
        goto(11);
        chk("s3_div_new", div_cur, 20);
        // Illegal loads while running
        goto(35);
        div_in = 16'd0; div_load = 1'b1;
        goto(36);
        div_load = 1'b0;
        chk("s4_err0", div_err, 1);
        chk("s4_div0", div_cur, 20);
        goto(37);
        chk("s4_err0_clr", div_err, 0);
        goto(40);
        div_in = 16'd1; div_load = 1'b1;
        goto(41);
        div_load = 1'b0;
        chk("s4_err1", div_err, 1);
        chk("s4_div1", div_cur, 20);
        goto(72);
        ena = 1'b0;
        goto(73);
        settle("s34");

        // Latest pending value wins; pending applied when ena falls
        start_with(10, 1'b0);
        goto(2);
        div_in = 16'd30; div_load = 1'b1;
        goto(3);
        div_load = 1'b0;
        goto(4);
        div_in = 16'd40; div_load = 1'b1;
        goto(5);
        div_load = 1'b0;
        expect_tick(1); expect_tick(11);
        goto(12);
        chk("s3b_latest", div_cur, 40);
        goto(13);
        div_in = 16'd7; div_load = 1'b1;
        goto(14);
        div_load = 1'b0;
        chk("s3b_pending_held", div_cur, 40);
        goto(15);
        ena = 1'b0;
        goto(16);
        chk("s3b_pending_on_stop", div_cur, 7);
        chk("s3b_run", run, 0);
        settle("s3b");

        // Stop mid-period, restart with no phase memory
        start_with(10, 1'b0);
        expect_tick(1);
        goto(7);
        ena = 1'b0;
        goto(8);
        chk("s5_run_off", run, 0);
        goto(20);
        ena = 1'b1;
        expect_tick(21); expect_tick(31);
        goto(32);
        ena = 1'b0;
        goto(33);
        settle("s5");

        // Table of loads applied in IDLE
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            div_in   = vecs[i].v_in;
            div_load = 1'b1;
            @(negedge clk);
            div_load = 1'b0;
            chk($sformatf("tbl%0d_err", i), div_err, vecs[i].v_err);
            chk($sformatf("tbl%0d_div", i), div_cur, vecs[i].v_cur);
            @(negedge clk);
            chk($sformatf("tbl%0d_err_clr", i), div_err, 0);
        end

        // Asynchronous reset mid-period drops the pending load
        start_with(10, 1'b0);
        expect_tick(1); expect_tick(11);
        goto(11);
        div_in = 16'd50; div_load = 1'b1;
        goto(12);
        div_load = 1'b0;
        goto(15);
        #2;
        rstn = 1'b0;
        #1;
        chk("s6_tick", tick, 0);
        chk("s6_run", run, 0);
        chk("s6_div", div_cur, 104);
        ena = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        settle("s6");
        begin_scn();
        ena = 1'b1; mode = 1'b0;
        expect_tick(1); expect_tick(105);
        goto(106);
        ena = 1'b0;
        goto(107);
        settle("s6_restart");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
